// File: rtl/apb2axi_pkg.sv
// rtl/apb2axi_pkg.sv - shared FSM state type and AXI encodings for the APB-to-AXI bridge
package apb2axi_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      DONE    = 3'd5
   } state_e;

   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/apb2axi_bridge.sv
// rtl/apb2axi_bridge.sv - APB completer issuing one single-beat AXI4 transaction per transfer
// Optional APB4_EN adds pstrb_i/pprot_i; without it strobes are all-ones and prot is 0.
module apb2axi_bridge
   import apb2axi_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 6,
   parameter int unsigned AXI_USER_WIDTH = 6,
   parameter int unsigned AXI_ID         = 0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        psel_i,
   input  logic                        penable_i,
   input  logic                        pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0]   paddr_i,
   input  logic [31:0]                 pwdata_i,
`ifdef APB4_EN
   input  logic [3:0]                  pstrb_i,
   input  logic [2:0]                  pprot_i,
`endif
   output logic [31:0]                 prdata_o,
   output logic                        pready_o,
   output logic                        pslverr_o,
   output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
   output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
   output logic [7:0]                  aw_len_o,
   output logic [2:0]                  aw_size_o,
   output logic [1:0]                  aw_burst_o,
   output logic                        aw_lock_o,
   output logic [3:0]                  aw_cache_o,
   output logic [2:0]                  aw_prot_o,
   output logic [3:0]                  aw_qos_o,
   output logic [3:0]                  aw_region_o,
   output logic [AXI_USER_WIDTH-1:0]   aw_user_o,
   output logic                        aw_valid_o,
   input  logic                        aw_ready_i,
   output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
   output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
   output logic                        w_last_o,
   output logic [AXI_USER_WIDTH-1:0]   w_user_o,
   output logic                        w_valid_o,
   input  logic                        w_ready_i,
   input  logic [AXI_ID_WIDTH-1:0]     b_id_i,
   input  logic [1:0]                  b_resp_i,
   input  logic [AXI_USER_WIDTH-1:0]   b_user_i,
   input  logic                        b_valid_i,
   output logic                        b_ready_o,
   output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
   output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
   output logic [7:0]                  ar_len_o,
   output logic [2:0]                  ar_size_o,
   output logic [1:0]                  ar_burst_o,
   output logic                        ar_lock_o,
   output logic [3:0]                  ar_cache_o,
   output logic [2:0]                  ar_prot_o,
   output logic [3:0]                  ar_qos_o,
   output logic [3:0]                  ar_region_o,
   output logic [AXI_USER_WIDTH-1:0]   ar_user_o,
   output logic                        ar_valid_o,
   input  logic                        ar_ready_i,
   input  logic [AXI_ID_WIDTH-1:0]     r_id_i,
   input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
   input  logic [1:0]                  r_resp_i,
   input  logic                        r_last_i,
   input  logic [AXI_USER_WIDTH-1:0]   r_user_i,
   input  logic                        r_valid_i,
   output logic                        r_ready_o
);

   state_e                    state_q, state_d;
   logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]               wdata_q, wdata_d;
   logic [3:0]                strb_q, strb_d;
   logic [2:0]                prot_q, prot_d;
   logic                      aw_done_q, aw_done_d;
   logic                      w_done_q, w_done_d;
   logic [31:0]               rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic [31:0]               rd_lane;
   logic                      aw_hs, w_hs;
   logic                      unused_inputs;

   assign unused_inputs = ^{b_id_i, b_user_i, r_id_i, r_last_i, r_user_i, paddr_i[1:0]};

   if (AXI_DATA_WIDTH == 64) begin : g_axi64
      assign w_data_o = {2{wdata_q}};
      assign w_strb_o = addr_q[2] ? {strb_q, 4'h0} : {4'h0, strb_q};
      assign rd_lane  = addr_q[2] ? r_data_i[63:32] : r_data_i[31:0];
   end else begin : g_axi32
      if (AXI_DATA_WIDTH != 32) begin : g_bad_width
         $error("apb2axi_bridge: AXI_DATA_WIDTH must be 32 or 64");
      end
      assign w_data_o = wdata_q;
      assign w_strb_o = strb_q;
      assign rd_lane  = r_data_i[31:0];
   end

   assign aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
   assign aw_addr_o   = AXI_ADDR_WIDTH'(addr_q);
   assign aw_len_o    = 8'd0;
   assign aw_size_o   = AXI_SIZE_4B;
   assign aw_burst_o  = AXI_BURST_INCR;
   assign aw_lock_o   = 1'b0;
   assign aw_cache_o  = 4'd0;
   assign aw_prot_o   = prot_q;
   assign aw_qos_o    = 4'd0;
   assign aw_region_o = 4'd0;
   assign aw_user_o   = '0;
   assign w_last_o    = 1'b1;
   assign w_user_o    = '0;
   assign ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
   assign ar_addr_o   = AXI_ADDR_WIDTH'(addr_q);
   assign ar_len_o    = 8'd0;
   assign ar_size_o   = AXI_SIZE_4B;
   assign ar_burst_o  = AXI_BURST_INCR;
   assign ar_lock_o   = 1'b0;
   assign ar_cache_o  = 4'd0;
   assign ar_prot_o   = prot_q;
   assign ar_qos_o    = 4'd0;
   assign ar_region_o = 4'd0;
   assign ar_user_o   = '0;

   // AW and W retire independently; each drops once its own handshake is recorded
   assign aw_valid_o = (state_q == WR_REQ) && !aw_done_q;
   assign w_valid_o  = (state_q == WR_REQ) && !w_done_q;
   assign b_ready_o  = (state_q == WR_RESP);
   assign ar_valid_o = (state_q == RD_REQ);
   assign r_ready_o  = (state_q == RD_RESP);
   assign pready_o   = (state_q == DONE);
   assign pslverr_o  = (state_q == DONE) && err_q;
   assign prdata_o   = rdata_q;

   assign aw_hs = aw_valid_o && aw_ready_i;
   assign w_hs  = w_valid_o && w_ready_i;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      prot_d    = prot_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (psel_i && !penable_i) begin
               addr_d    = {paddr_i[APB_ADDR_WIDTH-1:2], 2'b00};
               wdata_d   = pwdata_i;
`ifdef APB4_EN
               strb_d    = pstrb_i;
               prot_d    = pprot_i;
`else
               strb_d    = 4'hF;
               prot_d    = 3'b000;
`endif
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = pwrite_i ? WR_REQ : RD_REQ;
            end
         end
         WR_REQ: begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (b_valid_i) begin
               err_d   = b_resp_i[1];
               rdata_d = '0;
               state_d = DONE;
            end
         end
         RD_REQ: begin
            if (ar_ready_i) state_d = RD_RESP;
         end
         RD_RESP: begin
            if (r_valid_i) begin
               err_d   = r_resp_i[1];
               rdata_d = rd_lane;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         prot_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         prot_q    <= prot_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_apb2axi_bridge.sv
// tb/tb_apb2axi_bridge.sv - directed bench for apb2axi_bridge with a latency/payload model; APB4_EN aware
module tb_apb2axi_bridge;

   logic clk = 1'b0;
   logic rst_i;
   always #5 clk = ~clk;

   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic [31:0] prdata_o;
   logic        pready_o, pslverr_o;
   logic [5:0]  aw_id_o, ar_id_o, b_id_i, r_id_i;
   logic [31:0] aw_addr_o, ar_addr_o;
   logic [7:0]  aw_len_o, ar_len_o;
   logic [2:0]  aw_size_o, ar_size_o, aw_prot_o, ar_prot_o;
   logic [1:0]  aw_burst_o, ar_burst_o, b_resp_i, r_resp_i;
   logic        aw_lock_o, ar_lock_o;
   logic [3:0]  aw_cache_o, ar_cache_o, aw_qos_o, ar_qos_o, aw_region_o, ar_region_o;
   logic [5:0]  aw_user_o, ar_user_o, w_user_o, b_user_i, r_user_i;
   logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i, w_last_o;
   logic [63:0] w_data_o, r_data_i;
   logic [7:0]  w_strb_o;
   logic        b_valid_i, b_ready_o, ar_valid_o, ar_ready_i, r_valid_i, r_ready_o, r_last_i;

   apb2axi_bridge dut (
      .clk_i(clk), .rst_i(rst_i),
      .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata),
`ifdef APB4_EN
      .pstrb_i(pstrb), .pprot_i(pprot),
`endif
      .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
      .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
      .aw_burst_o(aw_burst_o), .aw_lock_o(aw_lock_o), .aw_cache_o(aw_cache_o), .aw_prot_o(aw_prot_o),
      .aw_qos_o(aw_qos_o), .aw_region_o(aw_region_o), .aw_user_o(aw_user_o),
      .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
      .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o), .w_user_o(w_user_o),
      .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
      .b_id_i(b_id_i), .b_resp_i(b_resp_i), .b_user_i(b_user_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
      .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
      .ar_burst_o(ar_burst_o), .ar_lock_o(ar_lock_o), .ar_cache_o(ar_cache_o), .ar_prot_o(ar_prot_o),
      .ar_qos_o(ar_qos_o), .ar_region_o(ar_region_o), .ar_user_o(ar_user_o),
      .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
      .r_id_i(r_id_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i), .r_user_i(r_user_i),
      .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
   );

   int vec = 0;
   int err = 0;
   int cyc = 0;

   int          d_aw = 0, d_w = 0, d_b = 0, d_ar = 0, d_r = 0;
   logic [1:0]  cfg_resp = 2'b00;
   logic [63:0] cfg_rdata = '0;

   logic        exp_wr = 1'b0;
   logic [31:0] exp_addr = '0;
   logic [63:0] exp_wdata = '0;
   logic [7:0]  exp_strb = '0;
   logic [2:0]  exp_prot = '0;
   logic [31:0] exp_prdata = '0;
   logic        exp_err = 1'b0;
   int          exp_done = -1;

   int          aw_acc = 0, w_acc = 0, ar_acc = 0, aw_vc = 0, w_vc = 0;
   logic [7:0]  obs_strb = '0;
   logic [63:0] obs_wdata = '0;
   logic [2:0]  obs_awprot = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      vec++;
      if (act !== expv) begin
         err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [7:0] lane_strb(input logic [31:0] a, input logic [3:0] s);
      return a[2] ? {s, 4'h0} : {4'h0, s};
   endfunction

   // AXI subordinate: each ready/valid waits its configured number of cycles
   int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
   always @(negedge clk) begin
      b_id_i = '0; b_user_i = '0; r_id_i = '0; r_user_i = '0; r_last_i = 1'b1;
      b_resp_i = cfg_resp; r_resp_i = cfg_resp; r_data_i = cfg_rdata;
      if (rst_i) begin
         aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; ar_ready_i = 0; r_valid_i = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
         if (aw_valid_o) begin aw_ready_i = (aw_cnt >= d_aw); aw_cnt++; end else begin aw_ready_i = 0; aw_cnt = 0; end
         if (w_valid_o)  begin w_ready_i  = (w_cnt  >= d_w);  w_cnt++;  end else begin w_ready_i  = 0; w_cnt  = 0; end
         if (b_ready_o)  begin b_valid_i  = (b_cnt  >= d_b);  b_cnt++;  end else begin b_valid_i  = 0; b_cnt  = 0; end
         if (ar_valid_o) begin ar_ready_i = (ar_cnt >= d_ar); ar_cnt++; end else begin ar_ready_i = 0; ar_cnt = 0; end
         if (r_ready_o)  begin r_valid_i  = (r_cnt  >= d_r);  r_cnt++;  end else begin r_valid_i  = 0; r_cnt  = 0; end
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_i) begin
         if (aw_valid_o) aw_vc <= aw_vc + 1;
         if (w_valid_o)  w_vc  <= w_vc + 1;
         if (aw_valid_o && aw_ready_i) begin aw_acc <= aw_acc + 1; obs_awprot <= aw_prot_o; end
         if (w_valid_o && w_ready_i) begin
            w_acc <= w_acc + 1; obs_strb <= w_strb_o; obs_wdata <= w_data_o;
         end
         if (ar_valid_o && ar_ready_i) ar_acc <= ar_acc + 1;
      end
   end

   // Per-cycle compare against the expected transaction
   always @(negedge clk) begin
      if (!rst_i) begin
         chk("pready_timing", {63'd0, pready_o}, {63'd0, cyc == exp_done});
         if (pready_o) begin
            chk("prdata", {32'd0, prdata_o}, {32'd0, exp_prdata});
            chk("pslverr", {63'd0, pslverr_o}, {63'd0, exp_err});
         end else begin
            chk("pslverr_idle", {63'd0, pslverr_o}, 64'd0);
         end
         if (aw_valid_o)
            chk("aw_fields", {10'd0, aw_addr_o, aw_prot_o, aw_len_o, aw_size_o, aw_burst_o, aw_id_o},
                {10'd0, exp_addr, exp_prot, 8'd0, 3'b010, 2'b01, 6'd0});
         if (w_valid_o) begin
            chk("w_strb_last", {55'd0, w_strb_o, w_last_o}, {55'd0, exp_strb, 1'b1});
            chk("w_data", w_data_o, exp_wdata);
         end
         if (ar_valid_o)
            chk("ar_fields", {10'd0, ar_addr_o, ar_prot_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o},
                {10'd0, exp_addr, exp_prot, 8'd0, 3'b010, 2'b01, 6'd0});
         chk("channel_dir", {62'd0, (aw_valid_o | w_valid_o | b_ready_o) & !exp_wr, (ar_valid_o | r_ready_o) & exp_wr}, 64'd0);
      end
   end

   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input logic [2:0] prot,
                       input int daw, input int dw, input int db, input int dar, input int dr,
                       input logic [1:0] resp, input logic [63:0] rd, input bit drop,
                       output int lat, output logic [31:0] prd, output logic perr);
      int t0;
      bit done;
      d_aw = daw; d_w = dw; d_b = db; d_ar = dar; d_r = dr;
      cfg_resp = resp; cfg_rdata = rd;
      exp_wr = wr;
      exp_addr = {addr[31:2], 2'b00};
`ifdef APB4_EN
      exp_strb = lane_strb(addr, strb);
      exp_prot = prot;
`else
      exp_strb = lane_strb(addr, 4'hF);
      exp_prot = 3'b000;
`endif
      exp_wdata = {wd, wd};
      exp_prdata = wr ? 32'd0 : (addr[2] ? rd[63:32] : rd[31:0]);
      exp_err = resp[1];
      @(posedge clk); #1;
      psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb; pprot = prot;
      t0 = cyc;
      exp_done = t0 + (wr ? 3 + ((daw > dw) ? daw : dw) + db : 3 + dar + dr);
      @(posedge clk); #1 penable = 1;
      if (drop) begin @(posedge clk); #1 psel = 0; penable = 0; end
      done = 0;
      prd = '0; perr = 1'b0;
      for (int i = 0; i < 80 && !done; i++) begin
         @(negedge clk);
         done = pready_o;
         prd = prdata_o; perr = pslverr_o;
      end
      lat = cyc - t0;
      chk("completes", {63'd0, done}, 64'd1);
      @(posedge clk); #1 psel = 0; penable = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, b_aw, b_w, b_awv, b_wv;
      logic [31:0] prd;
      logic perr;
      bit done;
      rst_i = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 4'hF; pprot = 3'b000;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {57'd0, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, pready_o, pslverr_o}, 64'd0);
      chk("rst_prdata", {32'd0, prdata_o}, 64'd0);
      chk("rst_addr", {aw_addr_o, ar_addr_o}, 64'd0);
      @(posedge clk); #1 rst_i = 0;

      xfer(1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 0, 0, 0, 0, 2'b00, 64'd0, 0, lat, prd, perr);
      chk("wr_lat", lat, 3);
      chk("wr_strb_hi", {56'd0, obs_strb}, 64'hF0);
      chk("wr_data_hi", {32'd0, obs_wdata[63:32]}, 64'hDEAD_BEEF);
      chk("wr_err", {63'd0, perr}, 64'd0);

      xfer(0, 32'h8000_0000, 0, 4'hF, 3'b000, 0, 0, 0, 0, 0, 2'b00, 64'h1122_3344_5566_7788, 0, lat, prd, perr);
      chk("rd_lo", {32'd0, prd}, 64'h5566_7788);
      chk("rd_lat", lat, 3);
      xfer(0, 32'h8000_0006, 0, 4'hF, 3'b000, 0, 0, 0, 0, 0, 2'b00, 64'h1122_3344_5566_7788, 0, lat, prd, perr);
      chk("rd_hi", {32'd0, prd}, 64'h1122_3344);

      b_aw = aw_acc; b_w = w_acc; b_awv = aw_vc; b_wv = w_vc;
      xfer(1, 32'h0000_0100, 32'h0102_0304, 4'hF, 3'b000, 5, 0, 0, 0, 0, 2'b00, 64'd0, 0, lat, prd, perr);
      chk("aw_hold", aw_vc - b_awv, 6);
      chk("w_hold", w_vc - b_wv, 1);
      chk("aw_once", aw_acc - b_aw, 1);
      chk("w_once", w_acc - b_w, 1);
      chk("awdelay_lat", lat, 8);
      chk("wr_strb_lo", {56'd0, obs_strb}, 64'h0F);

      xfer(1, 32'h0000_1000, 32'hA5A5_5A5A, 4'hF, 3'b000, 0, 0, 2, 0, 0, 2'b10, 64'd0, 0, lat, prd, perr);
      chk("slverr", {63'd0, perr}, 64'd1);
      chk("slverr_prdata", {32'd0, prd}, 64'd0);
      chk("slverr_lat", lat, 5);

      xfer(0, 32'h0000_0010, 0, 4'hF, 3'b000, 0, 0, 0, 1, 3, 2'b11, 64'hCAFE_F00D_0BAD_BEEF, 0, lat, prd, perr);
      chk("decerr", {63'd0, perr}, 64'd1);
      chk("decerr_lane", {32'd0, prd}, 64'h0BAD_BEEF);
      chk("decerr_lat", lat, 7);

      xfer(1, 32'h0000_0020, 32'h7777_8888, 4'hF, 3'b000, 1, 3, 0, 0, 0, 2'b01, 64'd0, 0, lat, prd, perr);
      chk("exokay", {63'd0, perr}, 64'd0);
      chk("wdelay_lat", lat, 6);

      xfer(0, 32'h0000_0024, 0, 4'hF, 3'b000, 0, 0, 0, 2, 0, 2'b00, 64'h9999_AAAA_BBBB_CCCC, 1, lat, prd, perr);
      chk("drop_psel_lat", lat, 5);
      chk("drop_psel_data", {32'd0, prd}, 64'h9999_AAAA);
      xfer(1, 32'h0000_0028, 32'h1234_5678, 4'hF, 3'b000, 0, 0, 0, 0, 0, 2'b00, 64'd0, 0, lat, prd, perr);
      chk("after_drop_lat", lat, 3);

      // reset while waiting for R, then a clean read
      d_ar = 0; d_r = 20; cfg_resp = 2'b00; cfg_rdata = 64'hFEED_0000_0000_BEEF;
      exp_wr = 0; exp_addr = 32'h40; exp_prot = 3'b000; exp_done = -1;
      @(posedge clk); #1 psel = 1; penable = 0; pwrite = 0; paddr = 32'h40; pstrb = 4'hF; pprot = 3'b000;
      @(posedge clk); #1 penable = 1;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin @(negedge clk); done = r_ready_o; end
      chk("reach_rd_resp", {63'd0, done}, 64'd1);
      @(posedge clk); #1 rst_i = 1; psel = 0; penable = 0;
      @(negedge clk);
      chk("rst_mid", {58'd0, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, pready_o}, 64'd0);
      @(posedge clk); #1 rst_i = 0;
      xfer(0, 32'h0000_0044, 0, 4'hF, 3'b000, 0, 0, 0, 0, 0, 2'b00, 64'hFEED_F00D_0000_BEEF, 0, lat, prd, perr);
      chk("post_rst_rd", {32'd0, prd}, 64'hFEED_F00D);
      chk("post_rst_lat", lat, 3);

`ifdef APB4_EN
      xfer(1, 32'h0000_0004, 32'h0BAD_CAFE, 4'b0101, 3'b011, 0, 0, 0, 0, 0, 2'b00, 64'd0, 0, lat, prd, perr);
      chk("apb4_strb", {56'd0, obs_strb}, 64'h50);
      chk("apb4_prot", {61'd0, obs_awprot}, 64'h3);
      xfer(1, 32'h0000_0008, 32'h0000_0001, 4'b0000, 3'b000, 0, 0, 0, 0, 0, 2'b00, 64'd0, 0, lat, prd, perr);
      chk("apb4_zero_strb", {56'd0, obs_strb}, 64'h00);
`endif

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
